// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_SKID  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [4:0]  OPC_HALT          = 5'b00000;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
    localparam logic [15:0] PC_INC            = 16'd2;

    function automatic logic is_halt(input logic [4:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding {instruction, pc+2} while decode is stalled.
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] din,
    output logic        full,
    output logic [31:0] dout
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            dout <= 32'h0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch FSM, PC register, IF/ID register and skid buffer.
// Build option FETCH_ALIGN_CHECK_EN: odd redirect targets raise a sticky err and halt.
//
// state    | meaning
// ST_FETCH | request outstanding at fetch_pc
// ST_SKID  | response parked in skid buffer, waiting for stall to drop
// ST_HALT  | HALT fetched or misaligned redirect; no requests issued
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] PC,
    output logic        valid,
    output logic        halted,
    output logic        err
);

    fetch_state_t state, state_next;
    logic [15:0]  fetch_pc;
    logic [15:0]  pc_inc;
    logic [15:0]  redir_pc_eff;
    logic         redir_odd;
    logic         resp, accept, to_skid, drain;
    logic         skid_full;
    logic [31:0]  skid_dout;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_pc_eff = redirect_pc;
    assign redir_odd    = redirect_pc[0];
`else
    assign redir_pc_eff = redirect_pc & 16'hFFFE;
    assign redir_odd    = 1'b0;
`endif

    assign pc_inc    = fetch_pc + PC_INC;
    assign imem_addr = fetch_pc;
    // A response in a redirect cycle belongs to the abandoned request and is dropped.
    assign resp      = (state == ST_FETCH) && imem_ready && !redirect;
    assign accept    = resp && !stall;
    assign to_skid   = resp && stall;
    assign drain     = (state == ST_SKID) && skid_full && !stall && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = redir_odd ? ST_HALT : ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (accept)
                        state_next = is_halt(imem_rdata[15:11]) ? ST_HALT : ST_FETCH;
                    else if (to_skid)
                        state_next = ST_SKID;
                end
                ST_SKID: begin
                    if (drain)
                        state_next = is_halt(skid_dout[31:27]) ? ST_HALT : ST_FETCH;
                end
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req = (state == ST_FETCH);
        halted   = (state == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          fetch_pc <= RESET_PC;
        else if (redirect) fetch_pc <= redir_pc_eff;
        else if (resp)     fetch_pc <= pc_inc;
    end

    // Decode consumes IF/ID whenever it is not stalling, so an empty cycle inserts a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr <= NOP_INSTR;
            PC    <= 16'h0000;
            valid <= 1'b0;
        end else if (redirect) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (accept) begin
            instr <= imem_rdata;
            PC    <= pc_inc;
            valid <= 1'b1;
        end else if (drain) begin
            instr <= skid_dout[31:16];
            PC    <= skid_dout[15:0];
            valid <= 1'b1;
        end else if (!stall) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       err <= 1'b0;
        else if (redirect && redir_odd) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    fetch_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (to_skid),
        .unload (drain),
        .clear  (redirect),
        .din    ({imem_rdata, pc_inc}),
        .full   (skid_full),
        .dout   (skid_dout)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model compared every cycle plus directed literal checks.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] instr;
    logic [15:0] PC;
    logic        valid;
    logic        halted;
    logic        err;

    int checks = 0;
    int failures = 0;
    logic check_en = 1'b0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .PC          (PC),
        .valid       (valid),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch address, pending-response queue, IF/ID contents.
    logic [15:0] m_pc, m_instr, m_pcid;
    logic        m_valid, m_halted, m_err;
    logic [31:0] m_skid[$];
    logic [31:0] m_e;

    function automatic void deliver(input logic [15:0] i, input logic [15:0] p);
        m_instr = i;
        m_pcid  = p;
        m_valid = 1'b1;
        if (i[15:11] == 5'b00000) m_halted = 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 16'h0000; m_instr = NOP; m_pcid = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
            m_skid.delete();
        end else if (redirect) begin
            m_skid.delete();
            m_instr = NOP;
            m_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            m_pc = redirect_pc;
            m_halted = redirect_pc[0];
            if (redirect_pc[0]) m_err = 1'b1;
`else
            m_pc = redirect_pc & 16'hFFFE;
            m_halted = 1'b0;
`endif
        end else if (!m_halted && m_skid.size() == 0 && imem_ready) begin
            if (stall) m_skid.push_back({imem_rdata, 16'(m_pc + 16'd2)});
            else       deliver(imem_rdata, 16'(m_pc + 16'd2));
            m_pc = m_pc + 16'd2;
        end else if (m_skid.size() != 0 && !stall) begin
            m_e = m_skid.pop_front();
            deliver(m_e[31:16], m_e[15:0]);
        end else if (!stall) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic exp_req;
        if (rst && check_en) begin
            exp_req = !m_halted && (m_skid.size() == 0);
            chk("m_imem_req", 16'(imem_req), 16'(exp_req));
            if (exp_req) chk("m_imem_addr", imem_addr, m_pc);
            chk("m_instr", instr, m_instr);
            chk("m_PC", PC, m_pcid);
            chk("m_valid", 16'(valid), 16'(m_valid));
            chk("m_halted", 16'(halted), 16'(m_halted));
            chk("m_err", 16'(err), 16'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_instr", instr, NOP);
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_PC", PC, 16'h0000);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        rst = 1'b1;
        check_en = 1'b1;

        // back-to-back zero-wait fetch
        imem_ready = 1'b1;
        imem_rdata = 16'h4000;
        chk("a_first_addr", imem_addr, 16'h0000);
        chk("a_first_req", 16'(imem_req), 16'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("a_instr", instr, 16'(16'h4000 + i));
            chk("a_PC", PC, 16'(2 * i + 2));
            chk("a_valid", 16'(valid), 16'h1);
            imem_rdata = 16'(16'h4000 + i + 1);
        end
        imem_ready = 1'b0;

        // three-cycle memory latency at 0x0010
        chk("b_addr0", imem_addr, 16'h0010);
        tick();
        chk("b_addr1", imem_addr, 16'h0010);
        chk("b_bubble", 16'(valid), 16'h0);
        tick();
        chk("b_addr2", imem_addr, 16'h0010);
        imem_ready = 1'b1; imem_rdata = 16'h5555;
        tick();
        chk("b_instr", instr, 16'h5555);
        chk("b_PC", PC, 16'h0012);
        imem_ready = 1'b0;

        // four-cycle stall, response in the second stall cycle
        stall = 1'b1;
        tick();
        chk("c_frozen1", instr, 16'h5555);
        chk("c_req1", 16'(imem_req), 16'h1);
        imem_ready = 1'b1; imem_rdata = 16'h6666;
        tick();
        chk("c_frozen2", instr, 16'h5555);
        chk("c_req_after_capture", 16'(imem_req), 16'h0);
        imem_ready = 1'b0;
        tick(); tick();
        chk("c_frozen4", instr, 16'h5555);
        chk("c_valid4", 16'(valid), 16'h1);
        stall = 1'b0;
        tick();
        chk("c_drain_instr", instr, 16'h6666);
        chk("c_drain_PC", PC, 16'h0014);
        chk("c_resume_addr", imem_addr, 16'h0014);
        tick();
        chk("c_no_dup", 16'(valid), 16'h0);

        // redirect abandons an outstanding request with same-cycle response
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("d_addr40", imem_addr, 16'h0040);
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        imem_ready = 1'b1; imem_rdata = 16'h7777;
        tick();
        chk("d_valid", 16'(valid), 16'h0);
        chk("d_instr", instr, NOP);
        chk("d_addr100", imem_addr, 16'h0100);
        redirect = 1'b0; imem_ready = 1'b0;

        // HALT fetched at 0x0006, then resumed by redirect
        redirect = 1'b1; redirect_pc = 16'h0004;
        tick();
        redirect = 1'b0;
        imem_ready = 1'b1; imem_rdata = 16'h1111;
        tick();
        chk("e_instr1", instr, 16'h1111);
        chk("e_addr6", imem_addr, 16'h0006);
        imem_rdata = 16'h0000;
        tick();
        chk("e_halt_instr", instr, 16'h0000);
        chk("e_halt_valid", 16'(valid), 16'h1);
        chk("e_halted", 16'(halted), 16'h1);
        chk("e_req0", 16'(imem_req), 16'h0);
        tick(); tick();
        chk("e_still_halted", 16'(halted), 16'h1);
        chk("e_still_noreq", 16'(imem_req), 16'h0);
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        chk("e_resume_req", 16'(imem_req), 16'h1);
        chk("e_resume_addr", imem_addr, 16'h0020);
        imem_rdata = 16'h2222;
        tick();
        chk("e_resume_instr", instr, 16'h2222);
        chk("e_resume_PC", PC, 16'h0022);
        imem_ready = 1'b0;

        // PC wrap at 0xFFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        imem_ready = 1'b1; imem_rdata = 16'h3333;
        tick();
        chk("f_wrap_PC", PC, 16'h0000);
        chk("f_wrap_addr", imem_addr, 16'h0000);
        chk("f_wrap_err", 16'(err), 16'h0);

        // stall and redirect together; redirect out of the skid state
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200; imem_rdata = 16'h4444;
        tick();
        chk("f_sr_valid", 16'(valid), 16'h0);
        chk("f_sr_addr", imem_addr, 16'h0200);
        redirect = 1'b0;
        tick();
        chk("f_skid_req", 16'(imem_req), 16'h0);
        imem_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0300;
        tick();
        chk("f_skid_redir_req", 16'(imem_req), 16'h1);
        chk("f_skid_redir_addr", imem_addr, 16'h0300);
        redirect = 1'b0; stall = 1'b0;
        tick();
        chk("f_skid_flushed", 16'(valid), 16'h0);
        chk("f_skid_flushed_instr", instr, NOP);

        // odd redirect target
        redirect = 1'b1; redirect_pc = 16'h0033;
        tick();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("g_err", 16'(err), 16'h1);
        chk("g_halted", 16'(halted), 16'h1);
        chk("g_noreq", 16'(imem_req), 16'h0);
        chk("g_valid", 16'(valid), 16'h0);
        tick();
        chk("g_noreq2", 16'(imem_req), 16'h0);
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("g_err_sticky", 16'(err), 16'h1);
        chk("g_resume_addr", imem_addr, 16'h0040);
`else
        chk("g_aligned_addr", imem_addr, 16'h0032);
        chk("g_req", 16'(imem_req), 16'h1);
        chk("g_err", 16'(err), 16'h0);
`endif

        // reset in the middle of an outstanding request
        imem_ready = 1'b1; imem_rdata = 16'h9999;
        #2 rst = 1'b0;
        tick();
        chk("h_rst_valid", 16'(valid), 16'h0);
        chk("h_rst_instr", instr, NOP);
        rst = 1'b1; imem_ready = 1'b0;
        tick();
        chk("h_addr", imem_addr, 16'h0000);
        chk("h_req", 16'(imem_req), 16'h1);
        chk("h_err", 16'(err), 16'h0);
        imem_ready = 1'b1; imem_rdata = 16'hABCD;
        tick();
        chk("h_instr", instr, 16'hABCD);
        chk("h_PC", PC, 16'h0002);
        imem_ready = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
